// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates plus blank/hsync/vsync, with the
// sync/blank group delayed to line up with the upstream pixel read latency.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIPE_DLY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] x_out,
  output logic [10:0] y_out,
  output logic        active_out,
  output logic        line_start_out,
  output logic        frame_start_out,
  output logic        blank_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 2048 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_param_err
    $error("video_timing_gen: illegal timing parameters");
  end

  // Phase lengths minus one: the phase counter runs down to zero.
  localparam logic [10:0] H_ACT_M1 = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_FP_M1  = 11'(H_FP - 1);
  localparam logic [10:0] H_SY_M1  = 11'(H_SYNC - 1);
  localparam logic [10:0] H_BP_M1  = 11'(H_BP - 1);
  localparam logic [10:0] V_ACT_M1 = 11'(V_ACTIVE - 1);
  localparam logic [10:0] V_FP_M1  = 11'(V_FP - 1);
  localparam logic [10:0] V_SY_M1  = 11'(V_SYNC - 1);
  localparam logic [10:0] V_BP_M1  = 11'(V_BP - 1);
  localparam logic        HS_ON    = 1'(HSYNC_POL);
  localparam logic        VS_ON    = 1'(VSYNC_POL);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC_S, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC_S, V_BACK} v_state_t;

  h_state_t    h_state;
  v_state_t    v_state;
  logic [10:0] h_phase, v_phase;
  logic [10:0] h_cnt, v_cnt;
  logic        h_end, v_end, act;

  logic [PIPE_DLY:0] blank_pipe, hs_pipe, vs_pipe;

  assign h_end = (h_state == H_BACK) && (h_phase == '0);
  assign v_end = (v_state == V_BACK) && (v_phase == '0);
  assign act   = (h_state == H_ACT) && (v_state == V_ACT);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_state <= H_ACT;
      h_phase <= H_ACT_M1;
      v_state <= V_ACT;
      v_phase <= V_ACT_M1;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 11'd1;
      if (h_phase == '0) begin
        case (h_state)
          H_ACT:    begin h_state <= H_FRONT;  h_phase <= H_FP_M1;  end
          H_FRONT:  begin h_state <= H_SYNC_S; h_phase <= H_SY_M1;  end
          H_SYNC_S: begin h_state <= H_BACK;   h_phase <= H_BP_M1;  end
          default:  begin h_state <= H_ACT;    h_phase <= H_ACT_M1; end
        endcase
      end else begin
        h_phase <= h_phase - 11'd1;
      end
      // Vertical side only moves on the last pixel of a line.
      if (h_end) begin
        v_cnt <= v_end ? '0 : v_cnt + 11'd1;
        if (v_phase == '0) begin
          case (v_state)
            V_ACT:    begin v_state <= V_FRONT;  v_phase <= V_FP_M1;  end
            V_FRONT:  begin v_state <= V_SYNC_S; v_phase <= V_SY_M1;  end
            V_SYNC_S: begin v_state <= V_BACK;   v_phase <= V_BP_M1;  end
            default:  begin v_state <= V_ACT;    v_phase <= V_ACT_M1; end
          endcase
        end else begin
          v_phase <= v_phase - 11'd1;
        end
      end
    end
  end

  // Stage 0 is aligned with x_out; stage PIPE_DLY drives the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out           <= '0;
      y_out           <= '0;
      active_out      <= 1'b0;
      line_start_out  <= 1'b0;
      frame_start_out <= 1'b0;
      blank_pipe      <= '1;
      hs_pipe         <= {(PIPE_DLY+1){~HS_ON}};
      vs_pipe         <= {(PIPE_DLY+1){~VS_ON}};
    end else begin
      x_out           <= h_cnt;
      y_out           <= v_cnt;
      active_out      <= act;
      line_start_out  <= (h_cnt == '0);
      frame_start_out <= (h_cnt == '0) && (v_cnt == '0);
      blank_pipe[0]   <= ~act;
      hs_pipe[0]      <= (h_state == H_SYNC_S) ? HS_ON : ~HS_ON;
      vs_pipe[0]      <= (v_state == V_SYNC_S) ? VS_ON : ~VS_ON;
      for (int i = 1; i <= PIPE_DLY; i++) begin
        blank_pipe[i] <= blank_pipe[i-1];
        hs_pipe[i]    <= hs_pipe[i-1];
        vs_pipe[i]    <= vs_pipe[i-1];
      end
    end
  end

  assign blank_out = blank_pipe[PIPE_DLY];
  assign hsync_out = hs_pipe[PIPE_DLY];
  assign vsync_out = vs_pipe[PIPE_DLY];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: four configurations run side by side, each
// compared every cycle against an arithmetic raster model.
module tb_video_timing_gen;

  typedef struct packed {int ha, hf, hsw, hb, va, vf, vsw, vb, hp, vp, d;} cfg_t;
  typedef struct packed {logic [10:0] x, y; logic act, ls, fs, blank, hs, vs;} exp_t;

  localparam cfg_t C0 = '{ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33, hp:0, vp:0, d:2};
  localparam cfg_t C1 = '{ha:16, hf:2, hsw:4, hb:3, va:12, vf:2, vsw:2, vb:3, hp:0, vp:0, d:2};
  localparam cfg_t C2 = '{ha:4, hf:1, hsw:2, hb:1, va:3, vf:1, vsw:1, vb:1, hp:1, vp:1, d:0};
  localparam cfg_t C3 = '{ha:16, hf:2, hsw:4, hb:3, va:12, vf:2, vsw:2, vb:3, hp:1, vp:0, d:8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst = '1;
  logic [10:0] xo[4], yo[4];
  logic        act[4], ls[4], fs[4], bl[4], hs[4], vs[4];
  int          n[4];
  int          vectors = 0, errors = 0;

  // n[k]: edges since reset release (0 = first edge with rst low), -1 in reset.
  always @(posedge clk)
    for (int k = 0; k < 4; k++) n[k] <= rst[k] ? -1 : n[k] + 1;

  video_timing_gen #(.H_ACTIVE(C0.ha), .H_FP(C0.hf), .H_SYNC(C0.hsw), .H_BP(C0.hb),
    .V_ACTIVE(C0.va), .V_FP(C0.vf), .V_SYNC(C0.vsw), .V_BP(C0.vb),
    .HSYNC_POL(C0.hp), .VSYNC_POL(C0.vp), .PIPE_DLY(C0.d)) u_dut0 (
    .clk(clk), .rst(rst[0]), .x_out(xo[0]), .y_out(yo[0]), .active_out(act[0]),
    .line_start_out(ls[0]), .frame_start_out(fs[0]), .blank_out(bl[0]),
    .hsync_out(hs[0]), .vsync_out(vs[0]));
  video_timing_gen #(.H_ACTIVE(C1.ha), .H_FP(C1.hf), .H_SYNC(C1.hsw), .H_BP(C1.hb),
    .V_ACTIVE(C1.va), .V_FP(C1.vf), .V_SYNC(C1.vsw), .V_BP(C1.vb),
    .HSYNC_POL(C1.hp), .VSYNC_POL(C1.vp), .PIPE_DLY(C1.d)) u_dut1 (
    .clk(clk), .rst(rst[1]), .x_out(xo[1]), .y_out(yo[1]), .active_out(act[1]),
    .line_start_out(ls[1]), .frame_start_out(fs[1]), .blank_out(bl[1]),
    .hsync_out(hs[1]), .vsync_out(vs[1]));
  video_timing_gen #(.H_ACTIVE(C2.ha), .H_FP(C2.hf), .H_SYNC(C2.hsw), .H_BP(C2.hb),
    .V_ACTIVE(C2.va), .V_FP(C2.vf), .V_SYNC(C2.vsw), .V_BP(C2.vb),
    .HSYNC_POL(C2.hp), .VSYNC_POL(C2.vp), .PIPE_DLY(C2.d)) u_dut2 (
    .clk(clk), .rst(rst[2]), .x_out(xo[2]), .y_out(yo[2]), .active_out(act[2]),
    .line_start_out(ls[2]), .frame_start_out(fs[2]), .blank_out(bl[2]),
    .hsync_out(hs[2]), .vsync_out(vs[2]));
  video_timing_gen #(.H_ACTIVE(C3.ha), .H_FP(C3.hf), .H_SYNC(C3.hsw), .H_BP(C3.hb),
    .V_ACTIVE(C3.va), .V_FP(C3.vf), .V_SYNC(C3.vsw), .V_BP(C3.vb),
    .HSYNC_POL(C3.hp), .VSYNC_POL(C3.vp), .PIPE_DLY(C3.d)) u_dut3 (
    .clk(clk), .rst(rst[3]), .x_out(xo[3]), .y_out(yo[3]), .active_out(act[3]),
    .line_start_out(ls[3]), .frame_start_out(fs[3]), .blank_out(bl[3]),
    .hsync_out(hs[3]), .vsync_out(vs[3]));

  function automatic cfg_t cfg_of(int k);
    case (k)
      0: return C0;
      1: return C1;
      2: return C2;
      default: return C3;
    endcase
  endfunction

  function automatic exp_t obs(int k);
    return '{xo[k], yo[k], act[k], ls[k], fs[k], bl[k], hs[k], vs[k]};
  endfunction

  // Raster position is pure arithmetic on the cycle count; sync/blank use the
  // position PIPE_DLY cycles earlier, inactive until that many cycles have run.
  function automatic exp_t model(cfg_t c, int cyc);
    int ht = c.ha + c.hf + c.hsw + c.hb;
    int vt = c.va + c.vf + c.vsw + c.vb;
    int m = cyc - c.d;
    int px, py;
    logic hon = (c.hp != 0);
    logic von = (c.vp != 0);
    exp_t e;
    e = '{x:11'd0, y:11'd0, act:1'b0, ls:1'b0, fs:1'b0, blank:1'b1, hs:~hon, vs:~von};
    if (cyc >= 0) begin
      px = cyc % ht;
      py = (cyc / ht) % vt;
      e.x = 11'(px);
      e.y = 11'(py);
      e.act = (px < c.ha) && (py < c.va);
      e.ls = (px == 0);
      e.fs = (px == 0) && (py == 0);
      if (m >= 0) begin
        px = m % ht;
        py = (m / ht) % vt;
        e.blank = !((px < c.ha) && (py < c.va));
        e.hs = (px >= c.ha + c.hf && px < c.ha + c.hf + c.hsw) ? hon : ~hon;
        e.vs = (py >= c.va + c.vf && py < c.va + c.vf + c.vsw) ? von : ~von;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    exp_t e, o;
    rst = '1;
    repeat (5) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        e = model(cfg_of(k), n[k]); o = obs(k); vectors++;
        if (o !== e) begin errors++; $display("FAIL reset_hold dut%0d got=%h want=%h", k, o, e); end
      end
    end
    rst = '0;
    repeat (12) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        e = model(cfg_of(k), n[k]); o = obs(k); vectors++;
        if (o !== e) begin errors++; $display("FAIL reset_release dut%0d n=%0d got=%h want=%h", k, n[k], o, e); end
      end
    end
  endtask

  task automatic test_horizontal();
    exp_t e, o;
    int ls_last = -1, hs_low = 0;
    for (int i = 0; i < 2400; i++) begin
      @(posedge clk); #1;
      e = model(C0, n[0]); o = obs(0); vectors++;
      if (o !== e) begin errors++; $display("FAIL horiz n=%0d got=%h want=%h", n[0], o, e); end
      if (ls[0]) begin
        if (ls_last >= 0) begin
          vectors++;
          if (n[0] - ls_last !== 800) begin errors++; $display("FAIL line_period got=%0d want=800", n[0] - ls_last); end
        end
        ls_last = n[0];
      end
      if (i < 800 && hs[0] == 1'b0) hs_low++;
    end
    vectors++;
    if (hs_low !== 96) begin errors++; $display("FAIL hsync_width got=%0d want=96", hs_low); end
  endtask

  task automatic test_vertical();
    exp_t e, o;
    int fs_last = -1, vs_low = 0;
    logic [10:0] px = '0, py = '0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      e = model(C1, n[1]); o = obs(1); vectors++;
      if (o !== e) begin errors++; $display("FAIL vert n=%0d got=%h want=%h", n[1], o, e); end
      if (fs[1]) begin
        if (fs_last >= 0) begin
          vectors++;
          if (n[1] - fs_last !== 475) begin errors++; $display("FAIL frame_period got=%0d want=475", n[1] - fs_last); end
        end
        fs_last = n[1];
      end
      if (i > 0 && xo[1] == 11'd0 && yo[1] == 11'd0) begin
        vectors++;
        if (px !== 11'd24 || py !== 11'd18) begin
          errors++; $display("FAIL vert_wrap prev x=%0d y=%0d want x=24 y=18", px, py);
        end
      end
      if (i < 475 && vs[1] == 1'b0) vs_low++;
      px = xo[1]; py = yo[1];
    end
    vectors++;
    if (vs_low !== 50) begin errors++; $display("FAIL vsync_width got=%0d want=50", vs_low); end
  endtask

  task automatic test_small();
    exp_t e, o;
    int fs_last = -1, hs_hi = 0, vs_hi = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      e = model(C2, n[2]); o = obs(2); vectors++;
      if (o !== e) begin errors++; $display("FAIL small n=%0d got=%h want=%h", n[2], o, e); end
      vectors++;
      if (hs[2] !== (xo[2] == 11'd5 || xo[2] == 11'd6)) begin
        errors++; $display("FAIL small_hsync_align x=%0d got=%b", xo[2], hs[2]);
      end
      if (fs[2]) begin
        if (fs_last >= 0) begin
          vectors++;
          if (n[2] - fs_last !== 48) begin errors++; $display("FAIL small_frame_period got=%0d want=48", n[2] - fs_last); end
        end
        fs_last = n[2];
      end
      if (i < 48) begin
        if (hs[2]) hs_hi++;
        if (vs[2]) vs_hi++;
      end
    end
    vectors++;
    if (hs_hi !== 12 || vs_hi !== 8) begin
      errors++; $display("FAIL small_sync_counts got hs=%0d vs=%0d want hs=12 vs=8", hs_hi, vs_hi);
    end
  endtask

  task automatic test_pipe8();
    exp_t e, o;
    int t_act = -1, t_h = -1, t_v = -1;
    logic pa = act[3], pb = bl[3], ph = hs[3], pv = vs[3];
    for (int i = 0; i < 950; i++) begin
      @(posedge clk); #1;
      e = model(C3, n[3]); o = obs(3); vectors++;
      if (o !== e) begin errors++; $display("FAIL pipe8 n=%0d got=%h want=%h", n[3], o, e); end
      if (act[3] && !pa) t_act = n[3];
      if (xo[3] == 11'd18) t_h = n[3];
      if (xo[3] == 11'd0 && yo[3] == 11'd14) t_v = n[3];
      if (pb && !bl[3] && t_act >= 0) begin
        vectors++;
        if (n[3] - t_act !== 8) begin errors++; $display("FAIL blank_lag got=%0d want=8", n[3] - t_act); end
      end
      if (!ph && hs[3] && t_h >= 0) begin
        vectors++;
        if (n[3] - t_h !== 8) begin errors++; $display("FAIL hsync_lag got=%0d want=8", n[3] - t_h); end
      end
      if (pv && !vs[3] && t_v >= 0) begin
        vectors++;
        if (n[3] - t_v !== 8) begin errors++; $display("FAIL vsync_lag got=%0d want=8", n[3] - t_v); end
      end
      pa = act[3]; pb = bl[3]; ph = hs[3]; pv = vs[3];
    end
  endtask

  task automatic test_midframe_reset();
    exp_t e, o;
    int tx, ty, hold, budget;
    // Default timing: hit reset in the middle of an hsync pulse.
    budget = 0;
    while (xo[0] != 11'd700 && budget < 900) begin @(posedge clk); #1; budget++; end
    vectors++;
    if (budget >= 900) begin errors++; $display("FAIL mid_reset0_wait got=timeout want=x700"); end
    rst[0] = 1'b1;
    @(posedge clk); #1;
    e = model(C0, n[0]); o = obs(0); vectors++;
    if (o !== e) begin errors++; $display("FAIL mid_reset0_state got=%h want=%h", o, e); end
    rst[0] = 1'b0;
    for (int i = 0; i < 900; i++) begin
      @(posedge clk); #1;
      e = model(C0, n[0]); o = obs(0); vectors++;
      if (o !== e) begin errors++; $display("FAIL mid_reset0_run n=%0d got=%h want=%h", n[0], o, e); end
    end
    // Small frame: random point, random hold length.
    tx = $urandom_range(0, 24); ty = $urandom_range(0, 18); hold = $urandom_range(1, 3);
    budget = 0;
    while (!(xo[1] == 11'(tx) && yo[1] == 11'(ty)) && budget < 600) begin @(posedge clk); #1; budget++; end
    vectors++;
    if (budget >= 600) begin errors++; $display("FAIL mid_reset1_wait got=timeout want=x%0d y%0d", tx, ty); end
    rst[1] = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      e = model(C1, n[1]); o = obs(1); vectors++;
      if (o !== e) begin errors++; $display("FAIL mid_reset1_state got=%h want=%h", o, e); end
    end
    rst[1] = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      e = model(C1, n[1]); o = obs(1); vectors++;
      if (o !== e) begin errors++; $display("FAIL mid_reset1_run n=%0d got=%h want=%h", n[1], o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_small();
    test_pipe8();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
